// File: rtl/calc_key_pkg.sv
// Shared types and constants for the hex calculator key-entry front end.
package calc_key_pkg;

  // Row counter width for the 4-row keypad.
  localparam int unsigned RowW = 2;

  // Keypad scan FSM states.
  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHold,
    StRelease
  } scan_state_e;

  // Hex value per key, indexed by {row, col}.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Returns {exactly_one_low, low_column_index} for an active-low column pattern.
  function automatic logic [2:0] low_col(logic [3:0] col);
    logic [2:0] res;
    case (col)
      4'b1110: res = 3'b100;
      4'b1101: res = 3'b101;
      4'b1011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calc_key_entry_if.sv
// Operand/command bus from the key-entry front end to the calculator core.
interface calc_key_entry_if;
  logic [7:0] num1;
  logic [7:0] num2;
  logic       sel;
  logic       key_valid;
  logic [3:0] key_code;
  logic       calc_btn;

  modport master (
    output num1, num2, sel, key_valid, key_code, calc_btn
  );

  modport slave (
    input num1, num2, sel, key_valid, key_code, calc_btn
  );
endinterface

// File: rtl/calc_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stable-level counter and a
// one-cycle pulse on each accepted released->pressed transition (active-high).
module calc_debounce #(
  parameter int unsigned DEB_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // State registers; debounced level starts released so reset never pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count cycles the synced input differs from the accepted level.
  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    level_d = level_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
      level_d = sync_q[1];
      cnt_d   = '0;
      press_o = sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/calc_key_entry.sv
// Hex calculator input front end: 4x4 keypad scan/debounce, operand nibble
// shift-in, operand select toggle and calculate pulse.
// Optional macro CALC_ENTRY_CLEAR_EN adds btn_clr, which zeroes the selected operand.
module calc_key_entry
  import calc_key_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES = 10000,
  parameter int unsigned DEB_CYCLES  = 200000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] kp_row,
  input  logic [3:0] kp_col,
  input  logic       btn_sel,
  input  logic       btn_go,
`ifdef CALC_ENTRY_CLEAR_EN
  input  logic       btn_clr,
`endif
  calc_key_entry_if.master bus
);

  localparam int unsigned CntMax = (SCAN_CYCLES > DEB_CYCLES) ? SCAN_CYCLES : DEB_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic [3:0]      col_s1_q, col_s2_q;
  scan_state_e     state_q, state_d;
  logic [RowW-1:0] row_q, row_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      pat_q, pat_d;
  logic [3:0]      kp_row_q, kp_row_d;
  logic [7:0]      num1_q, num1_d, num2_q, num2_d;
  logic            sel_q, sel_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            calc_btn_q, calc_btn_d;
  logic            key_fire;
  logic [2:0]      scan_dec, pat_dec;
  logic [3:0]      key_new;
  logic            sel_press, go_press, clr_press;

  calc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_sel),
    .press_o (sel_press)
  );

  calc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_go (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_go),
    .press_o (go_press)
  );

`ifdef CALC_ENTRY_CLEAR_EN
  calc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_clr),
    .press_o (clr_press)
  );
`else
  assign clr_press = 1'b0;
`endif

  assign scan_dec = low_col(col_s2_q);
  assign pat_dec  = low_col(pat_q);
  assign key_new  = KEYMAP[{row_q, pat_dec[1:0]}];

  // All state registers, including the column synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      state_q     <= StScan;
      row_q       <= '0;
      cnt_q       <= '0;
      pat_q       <= 4'hF;
      kp_row_q    <= 4'hF;
      num1_q      <= '0;
      num2_q      <= '0;
      sel_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      calc_btn_q  <= 1'b0;
    end else begin
      col_s1_q    <= kp_col;
      col_s2_q    <= col_s1_q;
      state_q     <= state_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      kp_row_q    <= kp_row_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      sel_q       <= sel_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      calc_btn_q  <= calc_btn_d;
    end
  end

  // Scan FSM: row slots, press debounce, hold until release, release debounce.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    key_fire = 1'b0;
    unique case (state_q)
      StScan: begin
        if (cnt_q == CntW'(SCAN_CYCLES - 1)) begin
          cnt_d = '0;
          if (scan_dec[2]) begin
            pat_d   = col_s2_q;
            state_d = StDebounce;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDebounce: begin
        if (col_s2_q != pat_q) begin
          state_d = StScan;
          row_d   = row_q + 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
          key_fire = 1'b1;
          state_d  = StHold;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (col_s2_q == 4'hF) begin
          state_d = StRelease;
          cnt_d   = '0;
        end
      end
      StRelease: begin
        if (col_s2_q != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
          state_d = StScan;
          row_d   = row_q + 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StScan;
    endcase
    kp_row_d = ~(4'b0001 << row_d);
  end

  // Operand update uses the pre-toggle sel; clear overrides a same-cycle digit.
  always_comb begin
    num1_d      = num1_q;
    num2_d      = num2_q;
    key_valid_d = key_fire;
    key_code_d  = key_fire ? key_new : key_code_q;
    if (key_fire) begin
      if (!sel_q) num1_d = {num1_q[3:0], key_new};
      else        num2_d = {num2_q[3:0], key_new};
    end
    if (clr_press) begin
      if (!sel_q) num1_d = '0;
      else        num2_d = '0;
    end
    sel_d      = sel_q ^ sel_press;
    calc_btn_d = go_press;
  end

  assign kp_row        = kp_row_q;
  assign bus.num1      = num1_q;
  assign bus.num2      = num2_q;
  assign bus.sel       = sel_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = key_code_q;
  assign bus.calc_btn  = calc_btn_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry with SCAN_CYCLES=4, DEB_CYCLES=8 and a
// behavioural 4x4 keypad model.
module tb_calc_key_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  kp_row;
  logic [3:0]  kp_col;
  logic        btn_sel = 1'b0;
  logic        btn_go  = 1'b0;
  logic [15:0] pressed = '0;
`ifdef CALC_ENTRY_CLEAR_EN
  logic        btn_clr = 1'b0;
`endif

  int errors   = 0;
  int checks   = 0;
  int kv_count = 0;
  int go_count = 0;

  calc_key_entry_if bus ();

  calc_key_entry #(
    .SCAN_CYCLES (4),
    .DEB_CYCLES  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .kp_row  (kp_row),
    .kp_col  (kp_col),
    .btn_sel (btn_sel),
    .btn_go  (btn_go),
`ifdef CALC_ENTRY_CLEAR_EN
    .btn_clr (btn_clr),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    kp_col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kp_row[r]) kp_col[c] = 1'b0;
      end
    end
  end

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) kv_count++;
    if (bus.calc_btn === 1'b1) go_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input int r, input int c, input int hold);
    pressed[r*4+c] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed[r*4+c] = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic pulse_sel();
    btn_sel = 1'b1;
    repeat (12) @(negedge clk);
    btn_sel = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  int kv0;
  int go0;
  int rise;
  logic found;

  initial begin
    // Reset state.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_kp_row", kp_row, 4'hF);
    chk("rst_num1", bus.num1, 8'h00);
    chk("rst_num2", bus.num2, 8'h00);
    chk("rst_sel", bus.sel, 1'b0);
    chk("rst_key_valid", bus.key_valid, 1'b0);
    chk("rst_key_code", bus.key_code, 4'h0);
    chk("rst_calc_btn", bus.calc_btn, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("scan_row0", kp_row, 4'b1110);

    // Long hold of key "6": exactly one accepted press.
    kv0 = kv_count;
    press(1, 2, 60);
    chk("k6_count", kv_count - kv0, 1);
    chk("k6_code", bus.key_code, 4'h6);
    chk("k6_num1", bus.num1, 8'h06);
    chk("k6_num2", bus.num2, 8'h00);

    // 3, A into num1; toggle sel; 5 into num2.
    press(0, 2, 40);
    press(0, 3, 40);
    pulse_sel();
    press(1, 1, 40);
    chk("op_num1", bus.num1, 8'h3A);
    chk("op_sel", bus.sel, 1'b1);
    chk("op_num2", bus.num2, 8'h05);

    // Back to num1; 1, 2, 3 shifts the oldest nibbles out.
    pulse_sel();
    chk("sel_back", bus.sel, 1'b0);
    press(0, 0, 40);
    press(0, 1, 40);
    press(0, 2, 40);
    chk("shift_num1", bus.num1, 8'h23);
    chk("shift_num2", bus.num2, 8'h05);

    // Chattering key on column 0 is never accepted.
    kv0 = kv_count;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) pressed[0] = ~pressed[0];
      @(negedge clk);
    end
    pressed[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("chatter_count", kv_count - kv0, 0);

    // Two columns low in one row is ignored.
    kv0 = kv_count;
    pressed[8] = 1'b1;
    pressed[9] = 1'b1;
    repeat (60) @(negedge clk);
    pressed[8] = 1'b0;
    pressed[9] = 1'b0;
    repeat (24) @(negedge clk);
    chk("twocol_count", kv_count - kv0, 0);
    chk("twocol_num1", bus.num1, 8'h23);

    // Go button held 12 cycles: one pulse, 10 cycles after the press.
    go0  = go_count;
    rise = -1;
    btn_go = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (bus.calc_btn === 1'b1 && rise < 0) rise = i;
      if (i == 12) btn_go = 1'b0;
    end
    repeat (10) @(negedge clk);
    chk("go_latency", rise, 10);
    chk("go_count", go_count - go0, 1);

    // 5-cycle glitch produces no pulse.
    go0 = go_count;
    btn_go = 1'b1;
    repeat (5) @(negedge clk);
    btn_go = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_count", go_count - go0, 0);

    // num1 = 3A, then reset while key "E" is being debounced.
    press(0, 3, 40);
    chk("pre_rst_num1", bus.num1, 8'h3A);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (kp_row === 4'b0111) found = 1'b1;
    end
    chk("row3_seen", found, 1'b1);
    pressed[12] = 1'b1;
    repeat (7) @(negedge clk);
    kv0 = kv_count;
    rst = 1'b0;
    pressed[12] = 1'b0;
    #1;
    chk("midrst_num1", bus.num1, 8'h00);
    chk("midrst_kp_row", kp_row, 4'hF);
    chk("midrst_key_valid", bus.key_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_count", kv_count - kv0, 0);
    chk("post_rst_num1", bus.num1, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
- Input-side front end of the hex calculator; the counterpart of the result/7-seg display path.
- Scans a 4x4 hex keypad, debounces keys and two pushbuttons, and assembles operands num1/num2 by nibble shift-in.
- Issues a one-cycle calculate pulse to the calculator core.
- Runs on the divided system clock.

Parameters:
- SCAN_CYCLES, 10000, clock cycles each keypad row is driven before advancing.
- DEB_CYCLES, 200000, stable cycles required to accept a press or a release.

Ports:
- clk  in  1  system clock (divided clock domain)
- rst  in  1  asynchronous, active-low reset
- kp_row  out  4  keypad row drive, active-low, one-hot-low while scanning
- kp_col  in  4  keypad column sense, active-low, asynchronous
- btn_sel  in  1  raw pushbutton; toggles the operand being edited
- btn_go  in  1  raw pushbutton; requests a calculation
- num1  out  8  operand 1
- num2  out  8  operand 2
- sel  out  1  0 = editing num1, 1 = editing num2
- key_valid  out  1  one-cycle pulse per accepted key
- key_code  out  4  hex value of the last accepted key
- calc_btn  out  1  one-cycle calculate pulse to the calculator core

Behaviour:
- Reset (rst=0, async): kp_row=4'b1111, num1=0, num2=0, sel=0, key_valid=0, key_code=0, calc_btn=0, scan FSM=SCAN at row 0, all counters=0.
- Synchronisation: kp_col, btn_sel and btn_go each pass through a 2-flop synchroniser before any use.
- FSM SCAN:
  - Drive kp_row low on the current row r for SCAN_CYCLES.
  - At slot end, sample the synced columns.
  - Exactly one column low -> latch {r,c} and go to DEBOUNCE, row held.
  - Zero or more than one column low -> r=(r+1) mod 4 and stay in SCAN.
- FSM DEBOUNCE:
  - Count while the column pattern equals the latched pattern.
  - Any change -> back to SCAN at the next row.
  - Count reaches DEB_CYCLES-1 -> key_valid=1 for one cycle, key_code=KEYMAP[{r,c}], go to HOLD.
- FSM HOLD: row held; wait for all columns high, then go to RELEASE.
- FSM RELEASE:
  - Count DEB_CYCLES consecutive cycles with all columns high, then go to SCAN at the next row.
  - Any column low restarts the count.
  - No auto-repeat: one press produces exactly one key_valid.
- KEYMAP (row0..row3, col0..col3):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- Operand entry: on key_valid, the selected operand <= {operand[3:0], key_code}. The older nibble falls off; no overflow flag. The unselected operand is unchanged.
- Button debounce: level must be stable DEB_CYCLES, then a one-cycle pulse on the released->pressed transition only.
  - sel pulse: sel <= ~sel.
  - go pulse: calc_btn=1 for exactly one cycle, registered.
- Simultaneous events:
  - key_valid with a sel pulse: the digit goes to the operand selected before the toggle.
  - key_valid with a go pulse: the digit updates the operand at the same edge calc_btn rises, so the core sees the new operands with the pulse.
- Latency: kp_col press to key_valid is at most 2 + 4*SCAN_CYCLES + DEB_CYCLES cycles. Button press to pulse is 2 + DEB_CYCLES cycles.
- Reset asserted mid-operation: everything returns to reset values immediately, with no pulse emitted on release of reset.

Optional Feature:
- Macro: CALC_ENTRY_CLEAR_EN.
- Defined:
  - Adds input port btn_clr (raw, 1 bit), debounced like the other buttons.
  - Its pulse sets the selected operand to 8'h00.
  - Clear takes priority over a same-cycle key_valid on that operand.
  - Clear with a sel pulse in the same cycle clears the pre-toggle operand.
- Undefined: no btn_clr port; operands change only by key shift-in.

Decomposition:
- Package calc_key_pkg:
  - KEYMAP constant array of 16 x 4-bit values.
  - Scan FSM state typedef {SCAN, DEBOUNCE, HOLD, RELEASE}.
  - Row-count width constant (2).
- Sub-module calc_debounce:
  - Synchroniser, stable counter, rising-edge pulse; parameter DEB_CYCLES.
  - Instantiated once per pushbutton: btn_sel, btn_go, and btn_clr when enabled.

Test Plan (SCAN_CYCLES=4, DEB_CYCLES=8):
- Hold key row1/col2 for 60 cycles, then release -> exactly one key_valid, key_code=6, num1=8'h06, num2=8'h00.
- Press 3, then A, then sel, then 5 -> num1=8'h3A, sel=1, num2=8'h05.
- Press 1, 2, 3 in sequence with sel=0 -> num1=8'h23, showing shift-out of the oldest nibble.
- Toggle column 0 low/high every 3 cycles for 40 cycles -> no key_valid. Likewise, holding two columns low in one row -> no key_valid.
- Pulse btn_go for 12 cycles -> calc_btn high for exactly 1 cycle, 10 cycles after rising; a 5-cycle btn_go glitch -> no pulse.
- Assert rst mid-DEBOUNCE with num1=8'h3A -> num1=0, kp_row=4'b1111, and no key_valid after reset is released.
